// File: rtl/coin_input_conditioner.sv
// Coin button front end: synchronises and debounces the three raw coin
// buttons, turns accepted presses into one-cycle one-hot coin codes,
// refuses presses during lockout or while the same coin is still queued,
// and keeps a saturating count of coins delivered.
//
// Arbiter states:
//   state | meaning
//   IDLE  | waiting for a pending coin; picks quarter > dime > nickel
//   EMIT  | coin carries the selected one-hot code for this cycle
//   GAP   | coin held at zero so back-to-back coins stay distinct
module coin_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic       clk50,
  input  logic       reset,
  input  logic [2:0] coin_btn,
  input  logic       lockout,
  output logic [2:0] coin,
  output logic       coin_return,
  output logic [7:0] coin_count
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_GAP  = 2'd2
  } arb_state_t;

  arb_state_t       state;
  logic [2:0]       sync_a;
  logic [2:0]       sync_b;
  logic [2:0]       stable;
  logic [2:0]       stable_d;
  logic [2:0]       press_q;
  logic [2:0]       pending;
  logic [CNT_W-1:0] cnt [3];

  logic [2:0] grant;
  logic [2:0] clear;
  logic [2:0] refuse;
  logic [2:0] accept;

  // Two-flop synchroniser for the asynchronous buttons.
  always_ff @(posedge clk50 or negedge reset) begin
    if (!reset) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= coin_btn;
      sync_b <= sync_a;
    end
  end

  // Per-bit debounce: stable flips only after DEBOUNCE_CYCLES consecutive mismatches.
  always_ff @(posedge clk50 or negedge reset) begin
    if (!reset) begin
      stable <= '0;
      for (int i = 0; i < 3; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (sync_b[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          stable[i] <= sync_b[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Registered rising edge of the debounced value; releases are ignored.
  always_ff @(posedge clk50 or negedge reset) begin
    if (!reset) begin
      stable_d <= '0;
      press_q  <= '0;
    end else begin
      stable_d <= stable;
      press_q  <= stable & ~stable_d;
    end
  end

  // Fixed priority select, and press acceptance against the post-clear pending set.
  always_comb begin
    grant = '0;
    if (pending[2])      grant = 3'b100;
    else if (pending[1]) grant = 3'b010;
    else if (pending[0]) grant = 3'b001;
  end

  assign clear  = (state == ST_IDLE) ? grant : 3'b000;
  assign refuse = press_q & ({3{lockout}} | (pending & ~clear));
  assign accept = press_q & ~refuse;

  // Arbiter FSM with pending queue and registered outputs.
  always_ff @(posedge clk50 or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      pending     <= '0;
      coin        <= '0;
      coin_return <= 1'b0;
      coin_count  <= '0;
    end else begin
      pending     <= (pending & ~clear) | accept;
      coin_return <= |refuse;
      coin        <= '0;
      case (state)
        ST_IDLE: begin
          if (|pending) begin
            state <= ST_EMIT;
            coin  <= grant;
          end
        end
        ST_EMIT: begin
          state <= ST_GAP;
          if (coin_count != 8'hFF) coin_count <= coin_count + 8'd1;
        end
        ST_GAP: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_coin_input_conditioner.sv
// Bench for coin_input_conditioner with a short debounce window. A
// timestamp-based reference model predicts coin, coin_return and
// coin_count every cycle; directed steps add scenario-level checks.
module tb_coin_input_conditioner;

  localparam int D = 4;

  logic       clk50 = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] coin_btn = 3'b000;
  logic       lockout = 1'b0;
  logic [2:0] coin;
  logic       coin_return;
  logic [7:0] coin_count;

  coin_input_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W(20)
  ) dut (
    .clk50(clk50),
    .reset(reset),
    .coin_btn(coin_btn),
    .lockout(lockout),
    .coin(coin),
    .coin_return(coin_return),
    .coin_count(coin_count)
  );

  always #5 clk50 = ~clk50;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // reference model state
  logic [2:0] b1, b2, m_stable, m_pending, exp_coin;
  logic       exp_ret;
  int         m_run [3];
  int         arrive_at [3];
  int         free_at, inc_at, m_count;

  // scenario bookkeeping
  int         coin_pulses, ret_pulses, last_coin_cyc, press_edge;
  logic [2:0] last_coin_code;
  logic [2:0] pcode [$];
  int         pcyc [$];
  int         hold [3];
  int         lhold;

  task model_reset();
    b1 = '0; b2 = '0; m_stable = '0; m_pending = '0;
    exp_coin = '0; exp_ret = 1'b0;
    for (int i = 0; i < 3; i++) begin
      m_run[i] = 0;
      arrive_at[i] = -1;
    end
    free_at = 0; inc_at = -1; m_count = 0;
  endtask

  // One clock edge of the reference: a pressed coin reaches the queue two
  // edges after its debounced rise; the arbiter can emit every third edge.
  task model_edge();
    logic [2:0] clr, acc;
    logic       refused;
    int         found;
    if (inc_at == cyc && m_count < 255) m_count++;
    clr = '0;
    exp_coin = '0;
    if (cyc >= free_at && m_pending != 0) begin
      found = 0;
      for (int i = 2; i >= 0; i--) begin
        if (m_pending[i] && found == 0) begin
          clr[i] = 1'b1;
          found = 1;
        end
      end
      exp_coin = clr;
      free_at = cyc + 3;
      inc_at = cyc + 1;
    end
    refused = 1'b0;
    acc = '0;
    for (int i = 0; i < 3; i++) begin
      if (arrive_at[i] == cyc) begin
        arrive_at[i] = -1;
        if (lockout || (m_pending[i] && !clr[i])) refused = 1'b1;
        else acc[i] = 1'b1;
      end
    end
    m_pending = (m_pending & ~clr) | acc;
    exp_ret = refused;
    for (int i = 0; i < 3; i++) begin
      if (b2[i] != m_stable[i]) begin
        m_run[i]++;
        if (m_run[i] == D) begin
          m_stable[i] = b2[i];
          m_run[i] = 0;
          if (b2[i]) arrive_at[i] = cyc + 2;
        end
      end else begin
        m_run[i] = 0;
      end
    end
    b2 = b1;
    b1 = coin_btn;
  endtask

  task chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task step();
    @(posedge clk50);
    cyc++;
    if (!reset) model_reset();
    else model_edge();
    #1;
    checks++;
    assert (coin === exp_coin)
    else begin
      errors++;
      $error("FAIL coin cyc=%0d observed=%b expected=%b", cyc, coin, exp_coin);
    end
    checks++;
    assert (coin_return === exp_ret)
    else begin
      errors++;
      $error("FAIL coin_return cyc=%0d observed=%b expected=%b", cyc, coin_return, exp_ret);
    end
    checks++;
    assert (coin_count === 8'(m_count))
    else begin
      errors++;
      $error("FAIL coin_count cyc=%0d observed=%0d expected=%0d", cyc, coin_count, m_count);
    end
    if (coin != 3'b000) begin
      coin_pulses++;
      last_coin_cyc = cyc;
      last_coin_code = coin;
      pcode.push_back(coin);
      pcyc.push_back(cyc);
    end
    if (coin_return) ret_pulses++;
  endtask

  task clear_stats();
    coin_pulses = 0;
    ret_pulses = 0;
    last_coin_cyc = -1;
    last_coin_code = '0;
    pcode.delete();
    pcyc.delete();
  endtask

  initial begin
    model_reset();
    clear_stats();
    repeat (3) step();
    reset = 1'b1;
    repeat (5) step();
    chk("reset_coin", coin, 0);
    chk("reset_count", coin_count, 0);

    // single dime held for 20 cycles
    clear_stats();
    coin_btn = 3'b010;
    press_edge = cyc + 1;
    repeat (20) step();
    coin_btn = 3'b000;
    repeat (20) step();
    chk("t1_pulses", coin_pulses, 1);
    chk("t1_latency", last_coin_cyc + 1 - press_edge, D + 5);
    chk("t1_code", last_coin_code, 2);
    chk("t1_count", coin_count, 1);
    chk("t1_return", ret_pulses, 0);

    // bouncing nickel, then a short quarter glitch
    clear_stats();
    for (int k = 0; k < 4; k++) begin
      coin_btn[0] = (k % 2 == 0);
      repeat (3) step();
    end
    coin_btn[0] = 1'b1;
    repeat (20) step();
    coin_btn[0] = 1'b0;
    repeat (20) step();
    chk("t2_bounce_pulses", coin_pulses, 1);
    chk("t2_bounce_code", last_coin_code, 1);
    clear_stats();
    coin_btn[2] = 1'b1;
    repeat (3) step();
    coin_btn[2] = 1'b0;
    repeat (20) step();
    chk("t2_glitch_pulses", coin_pulses, 0);

    // all three together
    clear_stats();
    coin_btn = 3'b111;
    repeat (25) step();
    coin_btn = 3'b000;
    repeat (25) step();
    chk("t3_pulses", pcode.size(), 3);
    if (pcode.size() == 3) begin
      chk("t3_first", pcode[0], 4);
      chk("t3_second", pcode[1], 2);
      chk("t3_third", pcode[2], 1);
      chk("t3_gap1", pcyc[1] - pcyc[0], 3);
      chk("t3_gap2", pcyc[2] - pcyc[1], 3);
    end
    chk("t3_count", coin_count, 5);

    // quarter during lockout is returned
    clear_stats();
    lockout = 1'b1;
    coin_btn = 3'b100;
    repeat (20) step();
    coin_btn = 3'b000;
    repeat (20) step();
    lockout = 1'b0;
    chk("t4_locked_pulses", coin_pulses, 0);
    chk("t4_return_cycles", ret_pulses, 1);

    // nickel queued behind a dime survives lockout rising
    clear_stats();
    coin_btn = 3'b011;
    repeat (10) step();
    lockout = 1'b1;
    repeat (15) step();
    coin_btn = 3'b000;
    repeat (20) step();
    lockout = 1'b0;
    chk("t4_queued_pulses", coin_pulses, 2);
    chk("t4_queued_last", last_coin_code, 1);
    chk("t4_queued_return", ret_pulses, 0);
    chk("t4_count", coin_count, 7);

    // randomized buttons and lockout against the model
    for (int i = 0; i < 3; i++) hold[i] = $urandom_range(1, 12);
    lhold = $urandom_range(5, 40);
    repeat (800) begin
      for (int i = 0; i < 3; i++) begin
        hold[i]--;
        if (hold[i] == 0) begin
          coin_btn[i] = ~coin_btn[i];
          hold[i] = $urandom_range(1, 12);
        end
      end
      lhold--;
      if (lhold == 0) begin
        lockout = ~lockout;
        lhold = $urandom_range(5, 40);
      end
      step();
    end
    coin_btn = 3'b000;
    lockout = 1'b0;
    repeat (30) step();

    // reset between debounce completion and EMIT
    coin_btn = 3'b010;
    repeat (7) step();
    reset = 1'b0;
    #1;
    model_reset();
    chk("t6_coin_in_reset", coin, 0);
    chk("t6_count_in_reset", coin_count, 0);
    clear_stats();
    coin_btn = 3'b000;
    repeat (4) step();
    reset = 1'b1;
    repeat (30) step();
    chk("t6_no_pulse", coin_pulses, 0);
    chk("t6_no_return", ret_pulses, 0);
    coin_btn = 3'b001;
    repeat (20) step();
    coin_btn = 3'b000;
    repeat (20) step();
    chk("t6_fresh_pulse", coin_pulses, 1);
    chk("t6_fresh_count", coin_count, 1);

    // 260 nickels: count saturates, pulses continue
    clear_stats();
    for (int p = 0; p < 260; p++) begin
      coin_btn = 3'b001;
      repeat (10) step();
      coin_btn = 3'b000;
      repeat (10) step();
    end
    chk("t5_pulses", coin_pulses, 260);
    chk("t5_count_sat", coin_count, 255);
    chk("t5_return", ret_pulses, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
